// File: rtl/mem_arbiter.sv
// Two-port arbiter for a shared 1024x32 distributed memory with lock bursts and 1-cycle responses.
// Optional macro MEM_ARB_PRIO0_EN: port 0 strict priority with port 1 anti-starvation instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_dpra,
    input  logic [DATA_W-1:0] mem_dpo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_reg;

    logic              grant0;
    logic              grant1;
    logic              pick1;

    logic              rsp0_valid_reg;
    logic              rsp1_valid_reg;
    logic [DATA_W-1:0] rsp0_rdata_reg;
    logic [DATA_W-1:0] rsp1_rdata_reg;

`ifdef MEM_ARB_PRIO0_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt_reg;

    // Port 1 only wins a contention once it has been passed over STARVE_LIMIT times.
    assign pick1 = (starve_cnt_reg == SW'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (grant1) begin
            starve_cnt_reg <= '0;
        end else if (req1_valid && (starve_cnt_reg != SW'(STARVE_LIMIT))) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end
`else
    logic rr_ptr_reg;

    assign pick1 = rr_ptr_reg;

    // After any accept the other port becomes preferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (grant0) begin
            rr_ptr_reg <= 1'b1;
        end else if (grant1) begin
            rr_ptr_reg <= 1'b0;
        end
    end
`endif

    // Grant implies valid, so a grant is also an accept.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        grant1 = pick1;
                        grant0 = !pick1;
                    end else begin
                        grant0 = req0_valid;
                        grant1 = req1_valid;
                    end
                end
                OWN0:    grant0 = req0_valid;
                OWN1:    grant1 = req1_valid;
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        mem_a    = '0;
        mem_dpra = '0;
        mem_d    = '0;
        mem_we   = 1'b0;
        if (grant0) begin
            mem_a    = req0_addr;
            mem_dpra = req0_addr;
            mem_d    = req0_wdata;
            mem_we   = req0_we;
        end else if (grant1) begin
            mem_a    = req1_addr;
            mem_dpra = req1_addr;
            mem_d    = req1_wdata;
            mem_we   = req1_we;
        end
    end

    // Ownership FSM and response registers; reads capture mem_dpo at the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rsp0_valid_reg <= 1'b0;
            rsp1_valid_reg <= 1'b0;
            rsp0_rdata_reg <= '0;
            rsp1_rdata_reg <= '0;
        end else begin
            rsp0_valid_reg <= grant0;
            rsp1_valid_reg <= grant1;
            if (grant0 && !req0_we) begin
                rsp0_rdata_reg <= mem_dpo;
            end
            if (grant1 && !req1_we) begin
                rsp1_rdata_reg <= mem_dpo;
            end
            case (state_reg)
                IDLE: begin
                    if (grant0 && req0_lock) begin
                        state_reg <= OWN0;
                    end else if (grant1 && req1_lock) begin
                        state_reg <= OWN1;
                    end
                end
                OWN0: begin
                    if (grant0 && !req0_lock) begin
                        state_reg <= IDLE;
                    end
                end
                OWN1: begin
                    if (grant1 && !req1_lock) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = rsp0_valid_reg;
    assign rsp1_valid = rsp1_valid_reg;
    assign rsp0_rdata = rsp0_rdata_reg;
    assign rsp1_rdata = rsp1_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (default round-robin build) with a behavioural memory.
module tb_mem_arbiter;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we, req0_lock;
    logic [9:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_lock;
    logic [9:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic [9:0]  mem_a, mem_dpra;
    logic [31:0] mem_d, mem_dpo;
    logic        mem_we;

    logic [31:0] mem [0:1023];

    int n_vec  = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
        .mem_dpra(mem_dpra), .mem_dpo(mem_dpo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
    end
    assign mem_dpo = mem[mem_dpra];

    typedef struct packed {
        logic        v0, we0, lk0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        v1, we1, lk1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic        r0, r1, mwe;
        logic [9:0]  ma;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic we0, input logic lk0, input logic [9:0] a0,
                         input logic [31:0] d0, input logic v1, input logic we1, input logic lk1,
                         input logic [9:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1; req1_wdata = d1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        rst = 1'b1;
        drive(F, F, F, 10'h0, 32'h0, F, F, F, 10'h0, 32'h0);

        //        v0 we0 lk0 a0      d0            v1 we1 lk1 a1      d1            r0 r1 mwe ma      rv0 rd0           rv1 rd1
        vecs[0]  = '{T, T, F, 10'h005, 32'hDEADBEEF, F, F, F, 10'h000, 32'h0,        T, F, T, 10'h005, T, 32'h0,        F, 32'h0};
        vecs[1]  = '{T, F, F, 10'h005, 32'h0,        F, F, F, 10'h000, 32'h0,        T, F, F, 10'h005, T, 32'hDEADBEEF, F, 32'h0};
        vecs[2]  = '{T, F, F, 10'h010, 32'h0,        T, F, F, 10'h020, 32'h0,        F, T, F, 10'h020, F, 32'hDEADBEEF, T, 32'hA0000020};
        vecs[3]  = '{T, F, F, 10'h010, 32'h0,        T, F, F, 10'h021, 32'h0,        T, F, F, 10'h010, T, 32'hA0000010, F, 32'hA0000020};
        vecs[4]  = '{T, F, F, 10'h011, 32'h0,        T, F, F, 10'h021, 32'h0,        F, T, F, 10'h021, F, 32'hA0000010, T, 32'hA0000021};
        vecs[5]  = '{T, F, F, 10'h011, 32'h0,        T, F, F, 10'h022, 32'h0,        T, F, F, 10'h011, T, 32'hA0000011, F, 32'hA0000021};
        vecs[6]  = '{T, F, F, 10'h012, 32'h0,        T, F, F, 10'h022, 32'h0,        F, T, F, 10'h022, F, 32'hA0000011, T, 32'hA0000022};
        vecs[7]  = '{T, F, F, 10'h012, 32'h0,        T, F, F, 10'h023, 32'h0,        T, F, F, 10'h012, T, 32'hA0000012, F, 32'hA0000022};
        vecs[8]  = '{T, F, F, 10'h013, 32'h0,        T, T, T, 10'h3FE, 32'h11111111, F, T, T, 10'h3FE, F, 32'hA0000012, T, 32'hA0000022};
        vecs[9]  = '{T, F, F, 10'h013, 32'h0,        T, T, T, 10'h3FF, 32'h22222222, F, T, T, 10'h3FF, F, 32'hA0000012, T, 32'hA0000022};
        vecs[10] = '{T, F, F, 10'h013, 32'h0,        T, T, F, 10'h000, 32'h33333333, F, T, T, 10'h000, F, 32'hA0000012, T, 32'hA0000022};
        vecs[11] = '{T, F, F, 10'h013, 32'h0,        T, F, F, 10'h3FE, 32'h0,        T, F, F, 10'h013, T, 32'hA0000013, F, 32'hA0000022};
        vecs[12] = '{F, F, F, 10'h000, 32'h0,        T, F, F, 10'h3FE, 32'h0,        F, T, F, 10'h3FE, F, 32'hA0000013, T, 32'h11111111};
        vecs[13] = '{F, F, F, 10'h000, 32'h0,        T, F, F, 10'h3FF, 32'h0,        F, T, F, 10'h3FF, F, 32'hA0000013, T, 32'h22222222};
        vecs[14] = '{F, F, F, 10'h000, 32'h0,        T, F, F, 10'h000, 32'h0,        F, T, F, 10'h000, F, 32'hA0000013, T, 32'h33333333};
        vecs[15] = '{T, T, T, 10'h100, 32'h44444444, F, F, F, 10'h000, 32'h0,        T, F, T, 10'h100, T, 32'hA0000013, F, 32'h33333333};
        vecs[16] = '{F, F, F, 10'h000, 32'h0,        F, F, F, 10'h000, 32'h0,        F, F, F, 10'h000, F, 32'hA0000013, F, 32'h33333333};
        vecs[17] = '{F, F, F, 10'h000, 32'h0,        T, F, F, 10'h100, 32'h0,        F, F, F, 10'h000, F, 32'hA0000013, F, 32'h33333333};
        vecs[18] = '{T, F, F, 10'h100, 32'h0,        T, F, F, 10'h100, 32'h0,        T, F, F, 10'h100, T, 32'h44444444, F, 32'h33333333};
        vecs[19] = '{F, F, F, 10'h000, 32'h0,        T, F, F, 10'h100, 32'h0,        F, T, F, 10'h100, F, 32'h44444444, T, 32'h44444444};

        // Reset: readies held low even with both ports requesting.
        repeat (2) @(posedge clk);
        #1;
        drive(T, F, F, 10'h001, 32'h0, T, F, F, 10'h002, 32'h0);
        #1;
        check("reset_ready0", {31'd0, req0_ready}, 32'd0);
        check("reset_ready1", {31'd0, req1_ready}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("reset_rsp0_rdata", rsp0_rdata, 32'd0);
        check("reset_rsp1_rdata", rsp1_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v0, vecs[i].we0, vecs[i].lk0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].we1, vecs[i].lk1, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].r0});
            check($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].r1});
            check($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mwe});
            check($sformatf("v%0d_mem_a", i), {22'd0, mem_a}, {22'd0, vecs[i].ma});
            check($sformatf("v%0d_mem_dpra", i), {22'd0, mem_dpra}, {22'd0, vecs[i].ma});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rsp0_valid", i), {31'd0, rsp0_valid}, {31'd0, vecs[i].rv0});
            check($sformatf("v%0d_rsp0_rdata", i), rsp0_rdata, vecs[i].rd0);
            check($sformatf("v%0d_rsp1_valid", i), {31'd0, rsp1_valid}, {31'd0, vecs[i].rv1});
            check($sformatf("v%0d_rsp1_rdata", i), rsp1_rdata, vecs[i].rd1);
            $display("vector %0d: ready0=%0b ready1=%0b mem_we=%0b rsp0=%0b/%h rsp1=%0b/%h",
                     i, vecs[i].r0, vecs[i].r1, vecs[i].mwe, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata);
        end

        // Reset right after a port 0 read accept drops the pending pulse and clears rr_ptr.
        drive(T, F, F, 10'h005, 32'h0, F, F, F, 10'h000, 32'h0);
        #1;
        check("mid_rst_accept0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(T, F, F, 10'h005, 32'h0, T, F, F, 10'h3FF, 32'h0);
        #1;
        check("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_rsp0_dropped", {31'd0, rsp0_valid}, 32'd0);
        check("mid_rst_rsp0_rdata", rsp0_rdata, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rr_ready0", {31'd0, req0_ready}, 32'd1);
        check("post_rst_rr_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
        $display("sequence reset-after-accept: rsp0=%0b/%h", rsp0_valid, rsp0_rdata);

        // Reset while port 1 owns the memory releases ownership.
        drive(F, F, F, 10'h000, 32'h0, T, T, T, 10'h200, 32'h55555555);
        #1;
        check("lock1_ready1", {31'd0, req1_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(T, F, F, 10'h200, 32'h0, F, F, F, 10'h000, 32'h0);
        #1;
        check("own1_cleared_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("own1_cleared_rsp0_rdata", rsp0_rdata, 32'h55555555);
        $display("sequence reset-in-OWN1: rsp0=%0b/%h", rsp0_valid, rsp0_rdata);

        drive(F, F, F, 10'h000, 32'h0, F, F, F, 10'h000, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the shared 1024x32 distributed data memory (one synchronous write port, one asynchronous read port) between two requesters: port 0 is the CPU load/store unit, port 1 is the loader/DMA engine. Each port uses a valid/ready request channel and a fixed-latency response channel. At most one access reaches the memory per cycle. An optional lock input lets a requester hold ownership across a burst.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data width
STARVE_LIMIT, 4, max consecutive denials of port 1 while port 0 has priority (used only with PRIO0_EN)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_lock  in  1  keep ownership after this beat
req0_addr  in  ADDR_W  word address
req0_wdata  in  DATA_W  write data
rsp0_valid  out  1  port 0 response pulse
rsp0_rdata  out  DATA_W  port 0 read data
req1_valid, req1_ready, req1_we, req1_lock, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1
mem_a  out  ADDR_W  memory write address
mem_d  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_dpra  out  ADDR_W  memory read address
mem_dpo  in  DATA_W  memory asynchronous read data

Behaviour:
- Reset: state=IDLE; rr_ptr=0 (port 0 preferred next); starve_cnt=0; rsp0_valid=rsp1_valid=0; rsp0_rdata=rsp1_rdata=0. While rst=1: req*_ready=0, mem_we=0.
- States: IDLE, OWN0, OWN1.
  - IDLE: winner is chosen by the arbitration rule among the valid requests.
  - OWNn: only port n may be granted. The other port's ready=0.
- Grant is combinational in the same cycle: reqN_ready=1 for the winner only, and only while reqN_valid=1. An accept is valid&&ready.
- Memory drive (combinational from the winner):
  - mem_a=mem_dpra=winner addr; mem_d=winner wdata; mem_we=winner we on accept.
  - With no accept: mem_we=0; mem_a/mem_dpra/mem_d=0.
- Response latency is 1 cycle.
  - Cycle after an accept on port n: rspN_valid=1 for exactly one cycle.
  - Read: rspN_rdata = mem_dpo sampled at the accept edge.
  - Write: rspN_rdata holds its previous value; the valid pulse is the write acknowledge.
  - rspN_rdata holds between responses.
- Responses have no backpressure; requesters must take them.
- Requester rule: while valid=1 and ready=0, addr/we/wdata/lock must stay stable. The arbiter never revokes ready within a cycle.
- Round-robin (default):
  - Both ports valid in IDLE: grant port rr_ptr.
  - Single valid port: grant it.
  - After each accept, rr_ptr = !granted_port.
- Lock transitions:
  - Accept on port n with reqN_lock=1: next state OWNn.
  - Accept in OWNn with lock=0: next state IDLE.
  - OWNn with reqN_valid=0: stay OWNn. Ownership is released only by an unlocked beat or by reset.
- Reset mid-operation: a pending response pulse is dropped (rsp valid cleared). A write accepted in the cycle rst=1 is impossible because ready=0.
- Back-to-back accepts on alternating ports sustain 1 access/cycle, with no idle bubble.
- Read of an address written in the previous cycle returns the new data, since the memory write completes at the edge.

Optional Feature:
- Macro: MEM_ARB_PRIO0_EN.
- Defined: IDLE arbitration is port 0 strict priority with anti-starvation.
  - starve_cnt increments each cycle port 1 is valid and denied; it clears on a port 1 accept.
  - When starve_cnt==STARVE_LIMIT, port 1 wins the next IDLE contention.
  - rr_ptr is unused.
- Not defined: round-robin only; starve_cnt logic is absent.

Test Plan:
- Reset, then port 0 writes 0xDEADBEEF at addr 0x005, then reads addr 0x005 → req0_ready=1 on both beats; mem_we=1 on beat 1; rsp0_valid pulses one cycle after each accept; second response has rsp0_rdata=0xDEADBEEF.
- Both ports read every cycle for 6 cycles (default build) → grants alternate 0,1,0,1,0,1; each rspN_valid one cycle after its own accept; no cycle with two readies.
- Port 1 issues 3 locked writes (lock=1,1,0) to addrs 0x3FE, 0x3FF, 0x000 while port 0 holds valid → port 0 stays stalled through all 3 beats and is granted the cycle after the unlocked beat; the address wrap at 0x3FF→0x000 is correct.
- MEM_ARB_PRIO0_EN, STARVE_LIMIT=4, both ports continuously valid → port 0 granted 4 cycles, port 1 granted the 5th, pattern repeats.
- Assert rst for 1 cycle in the cycle after a port 0 read accept → rsp0_valid=0 next cycle, state=IDLE, rr_ptr=0, all readies 0 during reset.
- Port 1 lock=1 beat, then rst → OWN1 is cleared; port 0 is granted immediately after reset.
